// File: rtl/antirebote_multicanal.sv
// ============================================================================
// Module   : antirebote_multicanal
// Purpose  : Multi-channel push-button debouncer with 2-flop synchronisers,
//            optional input inversion and optional press/release strobes
//            (strobes built only when ANTIREBOTE_PULSOS_EN is defined).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module antirebote_multicanal #(
    parameter int CANALES         = 4,
    parameter int CICLOS_ESTABLES = 30,
    parameter int ANCHO_CONTADOR  = $clog2(CICLOS_ESTABLES + 1),
    parameter int ACTIVO_BAJO     = 0
) (
    input  logic               reloj,
    input  logic               reinicio,
    input  logic [CANALES-1:0] entradaBoton,
    output logic [CANALES-1:0] salidaBoton,
    output logic [CANALES-1:0] pulsoPresion,
    output logic [CANALES-1:0] pulsoLiberacion,
    output logic               cambio
);

    localparam logic [ANCHO_CONTADOR-1:0] c_cuenta_fin = ANCHO_CONTADOR'(CICLOS_ESTABLES - 1);
    localparam logic [ANCHO_CONTADOR-1:0] c_uno        = ANCHO_CONTADOR'(1);
    localparam logic                      c_invertir   = (ACTIVO_BAJO != 0);

    logic [CANALES-1:0]        w_entrada;
    logic [CANALES-1:0]        w_acepta;
    logic [CANALES-1:0]        r_sinc1;
    logic [CANALES-1:0]        r_sinc2;
    logic [CANALES-1:0]        r_nivel;
    logic [ANCHO_CONTADOR-1:0] r_cont [CANALES];

    assign w_entrada   = entradaBoton ^ {CANALES{c_invertir}};
    assign salidaBoton = r_nivel;

    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            r_sinc1 <= '0;
            r_sinc2 <= '0;
        end else begin
            r_sinc1 <= w_entrada;
            r_sinc2 <= r_sinc1;
        end
    end

    generate
        for (genvar i = 0; i < CANALES; i++) begin : g_canal
            // A new level is taken on the clock where disagreement has lasted CICLOS_ESTABLES cycles.
            assign w_acepta[i] = (r_sinc2[i] != r_nivel[i]) && (r_cont[i] == c_cuenta_fin);

            always_ff @(posedge reloj or negedge reinicio) begin
                if (!reinicio) begin
                    r_cont[i]  <= '0;
                    r_nivel[i] <= 1'b0;
                end else if (r_sinc2[i] == r_nivel[i]) begin
                    r_cont[i] <= '0;
                end else if (w_acepta[i]) begin
                    r_nivel[i] <= r_sinc2[i];
                    r_cont[i]  <= '0;
                end else begin
                    r_cont[i] <= r_cont[i] + c_uno;
                end
            end
        end
    endgenerate

`ifdef ANTIREBOTE_PULSOS_EN
    logic [CANALES-1:0] r_presion;
    logic [CANALES-1:0] r_liberacion;
    logic               r_cambio;

    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            r_presion    <= '0;
            r_liberacion <= '0;
            r_cambio     <= 1'b0;
        end else begin
            r_presion    <= w_acepta & r_sinc2;
            r_liberacion <= w_acepta & ~r_sinc2;
            r_cambio     <= |w_acepta;
        end
    end

    assign pulsoPresion    = r_presion;
    assign pulsoLiberacion = r_liberacion;
    assign cambio          = r_cambio;
`else
    assign pulsoPresion    = '0;
    assign pulsoLiberacion = '0;
    assign cambio          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_antirebote_multicanal.sv
// ============================================================================
// Module   : tb_antirebote_multicanal
// Purpose  : Scoreboard bench for antirebote_multicanal against a time-based
//            reference model of the debounce rules.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_antirebote_multicanal;

    localparam int NC = 4;
    localparam int CE = 4;
    localparam int AB = 1;
    localparam int VW = 3 * NC + 1;
`ifdef ANTIREBOTE_PULSOS_EN
    localparam bit PULSOS = 1'b1;
`else
    localparam bit PULSOS = 1'b0;
`endif

    logic          reloj = 1'b0;
    logic          reinicio;
    logic [NC-1:0] entradaBoton;
    logic [NC-1:0] salidaBoton;
    logic [NC-1:0] pulsoPresion;
    logic [NC-1:0] pulsoLiberacion;
    logic          cambio;

    antirebote_multicanal #(
        .CANALES(NC), .CICLOS_ESTABLES(CE), .ACTIVO_BAJO(AB)
    ) dut (
        .reloj(reloj), .reinicio(reinicio), .entradaBoton(entradaBoton),
        .salidaBoton(salidaBoton), .pulsoPresion(pulsoPresion),
        .pulsoLiberacion(pulsoLiberacion), .cambio(cambio)
    );

    always #5 reloj = ~reloj;

    int edge_cnt = 0;
    always @(posedge reloj) edge_cnt = edge_cnt + 1;

    typedef struct {
        int            cyc;
        logic [VW-1:0] v;
    } ent_t;
    ent_t q[$];

    int checks = 0;
    int failures = 0;

    // Reference model: synchroniser samples plus the edge index at which
    // each channel was last "settled" (agreeing, just changed, or reset).
    logic [NC-1:0] m_s1 = '0, m_s2 = '0, m_niv = '0;
    int            m_ref [NC];

    task automatic model_edge(input int k, input logic [NC-1:0] raw, input logic rst);
        logic [NC-1:0] pr, li;
        ent_t e;
        pr = '0;
        li = '0;
        for (int ch = 0; ch < NC; ch++) begin
            if (!rst) begin
                m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_niv[ch] = 1'b0; m_ref[ch] = k;
            end else begin
                if (m_s2[ch] == m_niv[ch]) begin
                    m_ref[ch] = k;
                end else if (k - m_ref[ch] >= CE) begin
                    m_niv[ch] = m_s2[ch];
                    m_ref[ch] = k;
                    if (m_s2[ch]) pr[ch] = 1'b1;
                    else          li[ch] = 1'b1;
                end
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = raw[ch] ^ AB[0];
            end
        end
        if (!PULSOS) begin
            pr = '0;
            li = '0;
        end
        e.cyc = k;
        e.v   = {m_niv, pr, li, |(pr | li)};
        q.push_back(e);
    endtask

    task automatic step(input logic [NC-1:0] raw, input logic rst);
        @(posedge reloj);
        #3;
        entradaBoton = raw;
        reinicio     = rst;
        model_edge(edge_cnt + 1, raw, rst);
    endtask

    // Monitor: compares the DUT against the queued expectation for each edge.
    initial begin
        ent_t e;
        logic [VW-1:0] act;
        forever begin
            @(posedge reloj);
            #1;
            while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                e   = q.pop_front();
                act = {salidaBoton, pulsoPresion, pulsoLiberacion, cambio};
                checks++;
                if (e.cyc != edge_cnt) begin
                    failures++;
                    $display("FAIL stale_entry edge=%0d entry_edge=%0d", edge_cnt, e.cyc);
                end else if (act !== e.v) begin
                    failures++;
                    $display("FAIL outputs edge=%0d actual nivel=%b pres=%b lib=%b cambio=%b required nivel=%b pres=%b lib=%b cambio=%b",
                             edge_cnt, act[VW-1 -: NC], act[2*NC -: NC], act[NC -: NC], act[0],
                             e.v[VW-1 -: NC], e.v[2*NC -: NC], e.v[NC -: NC], e.v[0]);
                end
            end
        end
    end

    initial begin
        logic [NC-1:0] raw;
        logic          rst;
        int            hold [NC];
        int            rst_left;

        for (int ch = 0; ch < NC; ch++) m_ref[ch] = 0;
        raw          = '1;
        reinicio     = 1'b0;
        entradaBoton = raw;
        model_edge(1, raw, 1'b0);
        repeat (3) step(raw, 1'b0);
        repeat (3) step(raw, 1'b1);

        // Clean press and release on ch0 (raw active-low).
        raw[0] = 1'b0;
        repeat (2 * CE + 4) step(raw, 1'b1);
        raw[0] = 1'b1;
        repeat (2 * CE + 4) step(raw, 1'b1);

        // Simultaneous press on ch0 and ch3.
        raw[0] = 1'b0; raw[3] = 1'b0;
        repeat (2 * CE + 4) step(raw, 1'b1);
        raw = '1;
        repeat (2 * CE + 4) step(raw, 1'b1);

        // Bounce on ch1 faster than the stability window, then settle pressed.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) raw[1] = ~raw[1];
            step(raw, 1'b1);
        end
        raw[1] = 1'b0;
        repeat (2 * CE + 4) step(raw, 1'b1);

        // Reset in the middle of a count on ch3 while the button stays held.
        raw[3] = 1'b0;
        repeat (CE - 1) step(raw, 1'b1);
        repeat (3) step(raw, 1'b0);
        repeat (2 * CE + 4) step(raw, 1'b1);
        raw = '1;
        repeat (2 * CE + 4) step(raw, 1'b1);

        // Randomised bouncing on all channels with occasional resets.
        for (int ch = 0; ch < NC; ch++) hold[ch] = $urandom_range(1, 2 * CE + 2);
        rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < NC; ch++) begin
                if (hold[ch] == 0) begin
                    raw[ch]  = ~raw[ch];
                    hold[ch] = $urandom_range(1, 2 * CE + 2);
                end else begin
                    hold[ch]--;
                end
            end
            rst = 1'b1;
            if (rst_left > 0) begin
                rst = 1'b0;
                rst_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                rst_left = $urandom_range(0, 2);
            end
            step(raw, rst);
        end

        repeat (4) step(raw, 1'b1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge reloj);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual_pending=%0d required_pending=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
